dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder: the memory end of the core's load/store request/response interface.
// - Accepts one request at a time on a valid/ready channel.
// - Performs a word read or a byte-enabled write on an internal word array.
// - Returns the result on a valid/ready response channel after a programmable number of wait states.
// - Sits between the core's load/store stage and the memory array.
// PARAMETERS
// - DEPTH_WORDS  default 1024  number of 32-bit words; power of 2
// - AW           default 10    word-index width = $clog2(DEPTH_WORDS)
// - WAIT_CYCLES  default 1     extra wait states before response, range 0..15
// PORTS
// - clk        in   1   clock, rising edge
// - rst        in   1   reset, asynchronous, active-high
// - req_valid  in   1   request present
// - req_ready  out  1   responder can accept a request
// - req_addr   in   32  byte address
// - req_we     in   1   1 = write, 0 = read
// - req_be     in   4   byte enables; bit i selects wdata[8i+7:8i]
// - req_wdata  in   32  write data
// - rsp_valid  out  1   response present
// - rsp_ready  in   1   requester takes the response
// - rsp_rdata  out  32  read data; 0 for writes and errors
// - rsp_err    out  1   request rejected: misaligned or out of range
// BEHAVIOUR
// - Reset values:
//   - State = IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//   - req_ready=0 while rst is high.
//   - Array contents are not reset.
// - FSM states and transitions:
//   - IDLE: req_ready=1. On req_valid&&req_ready, latch addr/we/be/wdata.
//     - Go to WAIT if WAIT_CYCLES>0, else to RESP.
//   - WAIT: req_ready=0. Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
//     - Go to RESP on the cycle the counter equals 0.
//   - RESP: rsp_valid=1, req_ready=0. rdata/err are stable until the handshake.
//     - On rsp_valid&&rsp_ready, return to IDLE; rsp_valid=0 next cycle.
// - Latency: request accepted at edge T -> rsp_valid high from edge T+1+WAIT_CYCLES.
// - The response is held indefinitely while rsp_ready=0 (backpressure). No new request is accepted in that time.
// - Throughput: at most one transaction per 2+WAIT_CYCLES cycles. No request is accepted in the RESP handshake cycle.
// - Read: rsp_rdata = mem[addr[AW+1:2]], sampled on entry to RESP. req_be is ignored for reads.
// - Write:
//   - Bytes with be[i]=1 are updated on the edge entering RESP; the other bytes are unchanged.
//   - A write with be=0 is legal and changes nothing.
// - Read-after-write to the same word in back-to-back transactions returns the new data.
// - rst mid-transaction:
//   - The FSM aborts to IDLE and any pending response is dropped.
//   - A write already committed stays committed; an uncommitted write is lost.
// CONFIGURATION
// - Macro DMEM_ERR_CHECK_EN:
//   - Defined:
//     - rsp_err=1 if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
//     - Errored writes do not modify the array; errored reads return rdata=0.
//     - Latency and handshake are unchanged.
//   - Undefined:
//     - rsp_err is tied to 0.
//     - addr[1:0] are ignored and the word index wraps modulo DEPTH_WORDS, using addr[AW+1:2] only.
// TESTING
// - T1, write then read back:
//   - Write addr=0x10, be=4'hF, wdata=0xDEADBEEF -> rsp_valid, rsp_err=0, rdata=0.
//   - Then read 0x10 -> rdata=0xDEADBEEF at T+2 (WAIT_CYCLES=1).
// - T2, partial write:
//   - Preload 0x10=0xDEADBEEF, then write be=4'b0101, wdata=0x11223344.
//   - Read 0x10 -> rdata=0xDE22BE44.
// - T3, backpressure:
//   - Read with rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0.
//   - A new req_valid is not accepted until 1 cycle after rsp_ready=1.
// - T4, latency sweep:
//   - WAIT_CYCLES=0 -> rsp_valid at T+1.
//   - WAIT_CYCLES=3 -> rsp_valid at T+4.
//   - Check exact edges.
// - T5, errors (DMEM_ERR_CHECK_EN defined):
//   - Write to 0x13 -> rsp_err=1 and the array is unchanged.
//   - Read from DEPTH_WORDS*4 -> rsp_err=1, rdata=0.
//   - Undefined macro: the same read wraps to word 0.
// - T6, reset mid-transaction:
//   - Assert rst during WAIT -> rsp_valid=0, req_ready=0 immediately (asynchronous).
//   - After release: IDLE, req_ready=1, no stale response.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store request at a time, response after WAIT_CYCLES wait states.
// Optional address checking (misaligned / out of range) is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS),
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          commit;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic          cur_we;
  logic [AW-1:0] cur_idx;
  logic          cur_err;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  // With zero wait states the array is touched on the accept edge, so use the live request there.
  assign cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == S_IDLE) ? req_be    : be_q;
  assign cur_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign cur_idx   = cur_addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
  assign cur_err = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cur_addr[31:AW+2], cur_addr[1:0]};
  assign cur_err = 1'b0;
`endif

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign commit     = enter_resp && cur_we && !cur_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          we_d    = req_we;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_we || cur_err) ? 32'd0 : mem[cur_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; a write lands on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) begin
          mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
